ni_packet_injector: RTL and testbench

- Source-side network interface. Takes one packet request from the local core (destination x/y plus two 16-bit payload words) and serializes it into the 4-flit wormhole packet the routers consume: head, body1, body2, tail.
- Drives the router LOCAL input port through the downstream req/ack flit handshake.
- It is the transmitter counterpart of the router input buffer. One packet is in flight at a time.

---
 rtl/ni_packet_injector.sv | 125 ++++++++++++
 tb/tb_ni_packet_injector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packet_injector.sv
// Source-side network interface: turns one core packet request into a
// head/body1/body2/tail wormhole flit sequence on the router local port.
module ni_packet_injector #(
    parameter int FLIT_SIZE = 19,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid_i,
    output logic                 pkt_ready_o,
    input  logic [ADDR_BITS-1:0] dest_x_i,
    input  logic [ADDR_BITS-1:0] dest_y_i,
    input  logic [DATA_BITS-1:0] payload0_i,
    input  logic [DATA_BITS-1:0] payload1_i,
    output logic [FLIT_SIZE-1:0] flit_o,
    output logic                 flit_req_o,
    input  logic                 flit_ack_i,
    output logic                 busy_o,
    output logic [CNT_BITS-1:0]  pkt_sent_cnt_o
);

    localparam logic [1:0] TYPE_HEAD = 2'd0;
    localparam logic [1:0] TYPE_TAIL = 2'd1;
    localparam logic [1:0] TYPE_BODY = 2'd2;
    localparam logic [1:0] TYPE_NONE = 2'd3;

    localparam logic [FLIT_SIZE-1:0] IDLE_FLIT = {1'b0, TYPE_NONE, {DATA_BITS{1'b0}}};
    localparam logic [FLIT_SIZE-1:0] TAIL_FLIT = {1'b1, TYPE_TAIL, {DATA_BITS{1'b0}}};
    localparam logic [CNT_BITS-1:0]  CNT_ONE   = {{(CNT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY1,
        ST_BODY2,
        ST_TAIL
    } state_t;

    state_t                 state_reg, state_next;
    logic [FLIT_SIZE-1:0]   flit_reg, flit_next;
    logic                   req_reg, req_next;
    logic [CNT_BITS-1:0]    cnt_reg, cnt_next;
    logic [ADDR_BITS-1:0]   dest_x_reg, dest_y_reg;
    logic [DATA_BITS-1:0]   payload_reg [2];
    logic [DATA_BITS-1:0]   payload_in  [2];
    logic                   accept;
    logic                   tail_done;

    assign payload_in[0] = payload0_i;
    assign payload_in[1] = payload1_i;

    // Ready is combinational on ack so a new packet can enter on the tail-ack edge.
    assign tail_done   = (state_reg == ST_TAIL) && flit_ack_i;
    assign pkt_ready_o = (state_reg == ST_IDLE) || tail_done;
    assign accept      = pkt_valid_i && pkt_ready_o;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (accept)     state_next = ST_HEAD;
            ST_HEAD:  if (flit_ack_i) state_next = ST_BODY1;
            ST_BODY1: if (flit_ack_i) state_next = ST_BODY2;
            ST_BODY2: if (flit_ack_i) state_next = ST_TAIL;
            ST_TAIL:  if (flit_ack_i) state_next = accept ? ST_HEAD : ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Output flit is precomputed from the next state so flit_o is a plain flop.
    // The head on the accept edge must come from the live inputs, since the
    // holding registers load on that same edge.
    always_comb begin
        flit_next = IDLE_FLIT;
        unique case (state_next)
            ST_HEAD:  flit_next = accept ? {1'b1, TYPE_HEAD, dest_x_i, dest_y_i}
                                         : {1'b1, TYPE_HEAD, dest_x_reg, dest_y_reg};
            ST_BODY1: flit_next = {1'b1, TYPE_BODY, payload_reg[0]};
            ST_BODY2: flit_next = {1'b1, TYPE_BODY, payload_reg[1]};
            ST_TAIL:  flit_next = TAIL_FLIT;
            default:  flit_next = IDLE_FLIT;
        endcase
        req_next = (state_next != ST_IDLE);
        cnt_next = tail_done ? cnt_reg + CNT_ONE : cnt_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            flit_reg   <= IDLE_FLIT;
            req_reg    <= 1'b0;
            cnt_reg    <= '0;
            dest_x_reg <= '0;
            dest_y_reg <= '0;
        end else begin
            state_reg <= state_next;
            flit_reg  <= flit_next;
            req_reg   <= req_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                dest_x_reg <= dest_x_i;
                dest_y_reg <= dest_y_i;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_payload_hold
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    payload_reg[gi] <= '0;
                end else if (accept) begin
                    payload_reg[gi] <= payload_in[gi];
                end
            end
        end
    endgenerate

    assign flit_o         = flit_reg;
    assign flit_req_o     = req_reg;
    assign busy_o         = (state_reg != ST_IDLE);
    assign pkt_sent_cnt_o = cnt_reg;

endmodule

// File: tb/tb_ni_packet_injector.sv
// Bench for ni_packet_injector: directed scenarios plus randomized traffic
// checked every cycle against a queue-of-expected-flits reference model.
module tb_ni_packet_injector;

    localparam int CB = 6;  // narrow counter so the wrap is reachable quickly

    logic          clk = 1'b0;
    logic          rst;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [7:0]    dest_x, dest_y;
    logic [15:0]   payload0, payload1;
    logic [18:0]   flit;
    logic          flit_req;
    logic          flit_ack;
    logic          busy;
    logic [CB-1:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: flits still owed to the router, oldest first.
    logic [18:0]   exp_q [$];
    logic [CB-1:0] model_cnt = '0;
    int            accepts = 0;

    ni_packet_injector #(
        .FLIT_SIZE(19), .ADDR_BITS(8), .DATA_BITS(16), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst(rst),
        .pkt_valid_i(pkt_valid), .pkt_ready_o(pkt_ready),
        .dest_x_i(dest_x), .dest_y_i(dest_y),
        .payload0_i(payload0), .payload1_i(payload1),
        .flit_o(flit), .flit_req_o(flit_req), .flit_ack_i(flit_ack),
        .busy_o(busy), .pkt_sent_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Mid-cycle: compare DUT against the model, then advance the model to
    // what the coming edge will do with the inputs now applied.
    task automatic monitor();
        logic        exp_ready;
        logic [18:0] exp_flit;
        if (rst) begin
            exp_q.delete();
            model_cnt = '0;
        end else begin
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && flit_ack);
            exp_flit  = (exp_q.size() != 0) ? exp_q[0] : 19'h30000;
            chk("m_ready", 32'(pkt_ready), 32'(exp_ready));
            chk("m_flit",  32'(flit),      32'(exp_flit));
            chk("m_req",   32'(flit_req),  32'(exp_q.size() != 0));
            chk("m_busy",  32'(busy),      32'(exp_q.size() != 0));
            chk("m_cnt",   32'(cnt),       32'(model_cnt));
            if (exp_q.size() != 0 && flit_ack) begin
                if (exp_q.size() == 1) model_cnt = model_cnt + 1'b1;
                void'(exp_q.pop_front());
            end
            if (pkt_valid && exp_ready) begin
                exp_q.push_back({1'b1, 2'd0, dest_x, dest_y});
                exp_q.push_back({1'b1, 2'd2, payload0});
                exp_q.push_back({1'b1, 2'd2, payload1});
                exp_q.push_back(19'h50000);
                accepts++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor();
        end
    end

    task automatic drain();
        int g = 0;
        pkt_valid = 1'b0;
        flit_ack  = 1'b1;
        while (exp_q.size() != 0 && g < 200) begin
            step();
            g++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_pkt(input logic [7:0] x, input logic [7:0] y,
                           input logic [15:0] p0, input logic [15:0] p1);
        dest_x = x; dest_y = y; payload0 = p0; payload1 = p1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] seq [8];
        int          need;
        int          tgt;
        int          g;

        rst = 1'b1; pkt_valid = 1'b0; flit_ack = 1'b0;
        set_pkt(8'h0, 8'h0, 16'h0, 16'h0);
        @(negedge clk);
        chk("rst_flit",  32'(flit),      32'h30000);
        chk("rst_req",   32'(flit_req),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_cnt",   32'(cnt),       32'd0);
        chk("rst_ready", 32'(pkt_ready), 32'd1);
        step();
        rst = 1'b0;

        // Single packet, ack always high; inputs scrambled right after accept.
        step();
        set_pkt(8'd3, 8'd5, 16'hABCD, 16'h1234);
        pkt_valid = 1'b1; flit_ack = 1'b1;
        step();
        pkt_valid = 1'b0;
        set_pkt(8'hEE, 8'hDD, 16'h5555, 16'h7777);
        seq[0] = 19'h40305; seq[1] = 19'h6ABCD; seq[2] = 19'h61234; seq[3] = 19'h50000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("single_flit%0d", i), 32'(flit), 32'(seq[i]));
            chk($sformatf("single_req%0d", i),  32'(flit_req), 32'd1);
        end
        @(negedge clk);
        chk("single_idle", 32'(flit),      32'h30000);
        chk("single_req",  32'(flit_req),  32'd0);
        chk("single_cnt",  32'(cnt),       32'd1);
        chk("single_rdy",  32'(pkt_ready), 32'd1);

        // Backpressure: ack low for 3 edges while BODY1 is presented.
        step();
        set_pkt(8'd3, 8'd5, 16'hABCD, 16'h1234);
        pkt_valid = 1'b1; flit_ack = 1'b1;
        step();
        pkt_valid = 1'b0;
        @(negedge clk);
        chk("bp_head", 32'(flit), 32'h40305);
        step();
        flit_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) flit_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i),  32'(flit),      32'h6ABCD);
            chk($sformatf("bp_ready%0d", i), 32'(pkt_ready), 32'd0);
            step();
        end
        @(negedge clk);
        chk("bp_body2", 32'(flit), 32'h61234);
        @(negedge clk);
        chk("bp_tail", 32'(flit), 32'h50000);
        @(negedge clk);
        chk("bp_idle", 32'(flit), 32'h30000);
        chk("bp_cnt",  32'(cnt),  32'd2);

        // Back-to-back: valid held, second request follows the first tail.
        step();
        set_pkt(8'h12, 8'h34, 16'hBEEF, 16'hCAFE);
        pkt_valid = 1'b1; flit_ack = 1'b1;
        step();
        set_pkt(8'h00, 8'hFF, 16'h0F0F, 16'hF00D);
        seq[0] = 19'h41234; seq[1] = 19'h6BEEF; seq[2] = 19'h6CAFE; seq[3] = 19'h50000;
        seq[4] = 19'h400FF; seq[5] = 19'h60F0F; seq[6] = 19'h6F00D; seq[7] = 19'h50000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_flit%0d", i), 32'(flit), 32'(seq[i]));
            step();
            if (i == 3) pkt_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", 32'(flit), 32'h30000);
        chk("b2b_cnt",  32'(cnt),  32'd4);

        // Asynchronous reset in the middle of BODY1.
        step();
        set_pkt(8'd1, 8'd2, 16'h1111, 16'h2222);
        pkt_valid = 1'b1; flit_ack = 1'b1;
        step();
        pkt_valid = 1'b0;
        step();
        flit_ack = 1'b0;
        @(negedge clk);
        chk("pre_rst_flit", 32'(flit), 32'h61111);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        #1;
        chk("async_rst_flit", 32'(flit),     32'h30000);
        chk("async_rst_req",  32'(flit_req), 32'd0);
        chk("async_rst_busy", 32'(busy),     32'd0);
        step();
        step();
        rst = 1'b0; flit_ack = 1'b1;
        @(negedge clk);
        chk("post_rst_cnt",   32'(cnt),       32'd0);
        chk("post_rst_ready", 32'(pkt_ready), 32'd1);

        // Randomized traffic under random backpressure.
        for (int i = 0; i < 400; i++) begin
            step();
            pkt_valid = ($urandom_range(0, 1) == 1);
            flit_ack  = ($urandom_range(0, 3) != 0);
            set_pkt(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
        end
        drain();

        // Counter wrap: stream until the count reaches all-ones, then one more.
        need = int'(6'(6'h3F - model_cnt));
        tgt = accepts + need;
        g = 0;
        flit_ack = 1'b1;
        pkt_valid = 1'b1;
        while (accepts < tgt && g < 2000) begin
            step();
            g++;
        end
        pkt_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("wrap_full", 32'(cnt), 32'h3F);
        step();
        set_pkt(8'd7, 8'd7, 16'h0001, 16'h0002);
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("wrap_zero", 32'(cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
